// File: rtl/store_fwd_hazard_unit.sv
// Store-data forwarding and load-use hazard unit.
// Chooses the EX/MEM store data from MEM/WB or a short history of retired
// writebacks, runs the load-use stall FSM and counts stalled cycles.
module store_fwd_hazard_unit #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned REG_AW          = 5,
  parameter int unsigned HIST_DEPTH      = 2,
  parameter logic [1:0]  MD_LOAD         = 2'b01,
  parameter bit          FWD_ALL         = 1'b0,
  parameter int unsigned LOAD_USE_STALLS = 1,
  localparam int unsigned SRC_W          = $clog2(HIST_DEPTH + 1) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        memwb_md,
  input  logic              memwb_rw,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_data,
  input  logic              exmem_mw,
  input  logic [REG_AW-1:0] exmem_rs2,
  input  logic [XLEN-1:0]   exmem_rs2_data,
  input  logic [1:0]        idex_md,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_use_rs1,
  input  logic              ifid_use_rs2,
  input  logic              ifid_mw,
  input  logic              flush,
  output logic [XLEN-1:0]   store_data,
  output logic              lwsw_sel,
  output logic [SRC_W-1:0]  fwd_src,
  output logic              stall,
  output logic [15:0]       stall_cycles
);

  // Counter only needs to reach LOAD_USE_STALLS-1.
  localparam int unsigned CNT_W = (LOAD_USE_STALLS > 1) ? $clog2(LOAD_USE_STALLS) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(LOAD_USE_STALLS - 1);

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  // ---------------------------------------------------------------------------
  // Writeback history
  // ---------------------------------------------------------------------------
  logic                                memwb_vld;
  logic [HIST_DEPTH-1:0]               hist_vld_q, hist_vld_d;
  logic [HIST_DEPTH-1:0][REG_AW-1:0]   hist_rd_q, hist_rd_d;
  logic [HIST_DEPTH-1:0][XLEN-1:0]     hist_data_q, hist_data_d;

  // A writeback is a forwarding candidate only if it really writes a nonzero register.
  assign memwb_vld = memwb_rw && (memwb_rd != '0) && (FWD_ALL || (memwb_md == MD_LOAD));

  // Shift MEM/WB into hist[0] every cycle; WB never stalls so no enable is needed.
  always_comb begin
    hist_vld_d  = hist_vld_q;
    hist_rd_d   = hist_rd_q;
    hist_data_d = hist_data_q;
    hist_vld_d[0]  = memwb_vld;
    hist_rd_d[0]   = memwb_rd;
    hist_data_d[0] = memwb_data;
    for (int i = 1; i < int'(HIST_DEPTH); i++) begin
      hist_vld_d[i]  = hist_vld_q[i-1];
      hist_rd_d[i]   = hist_rd_q[i-1];
      hist_data_d[i] = hist_data_q[i-1];
    end
  end

  // Valid bits are the only history state that needs reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_vld_q <= '0;
    end else begin
      hist_vld_q <= hist_vld_d;
    end
  end

  // Register index and data payload of the history entries.
  always_ff @(posedge clk) begin
    hist_rd_q   <= hist_rd_d;
    hist_data_q <= hist_data_d;
  end

  // ---------------------------------------------------------------------------
  // Store-data forwarding
  // ---------------------------------------------------------------------------
  // Oldest source is evaluated first so younger matches override it.
  always_comb begin
    lwsw_sel   = 1'b0;
    fwd_src    = '0;
    store_data = exmem_rs2_data;
    if (exmem_mw && (exmem_rs2 != '0)) begin
      for (int i = int'(HIST_DEPTH) - 1; i >= 0; i--) begin
        if (hist_vld_q[i] && (hist_rd_q[i] == exmem_rs2)) begin
          lwsw_sel   = 1'b1;
          fwd_src    = SRC_W'(i + 2);
          store_data = hist_data_q[i];
        end
      end
      if (memwb_vld && (memwb_rd == exmem_rs2)) begin
        lwsw_sel   = 1'b1;
        fwd_src    = SRC_W'(1);
        store_data = memwb_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard FSM
  // ---------------------------------------------------------------------------
  logic             det;
  logic             stall_raw;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Store data (rs2 of a store) is covered by forwarding, so it does not stall.
  always_comb begin
    det = (idex_md == MD_LOAD) && (idex_rd != '0) &&
          ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
           (ifid_use_rs2 && (ifid_rs2 == idex_rd) && !ifid_mw));
  end

  // Next state and stall request; flush overrides every stall source.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall_raw = det && !flush;
        if (det && !flush && (LOAD_USE_STALLS > 1)) begin
          state_d = StStall;
          cnt_d   = CNT_W'(1);
        end
      end
      StStall: begin
        stall_raw = !flush;
        if (flush || (cnt_q == CntLast)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Gating with rst drops stall immediately, even while det is still high.
  assign stall = stall_raw && !rst;

  // FSM state and stall-length counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cycles_q, stall_cycles_d;

  // Count stalled cycles, holding at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_store_fwd_hazard_unit.sv
// Directed bench for store_fwd_hazard_unit: two instances share stimulus,
// u1 (1 stall cycle, load-only forwarding) and u3 (3 stall cycles, forward all).
module tb_store_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  memwb_md, idex_md;
  logic        memwb_rw, exmem_mw, ifid_use_rs1, ifid_use_rs2, ifid_mw, flush;
  logic [4:0]  memwb_rd, exmem_rs2, idex_rd, ifid_rs1, ifid_rs2;
  logic [31:0] memwb_data, exmem_rs2_data;

  logic [31:0] sd1, sd3;
  logic        sel1, sel3, st1, st3;
  logic [2:0]  src1, src3;
  logic [15:0] sc1, sc3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  // Expected stall per cycle and reference stall counters.
  logic        e_st1 = 1'b0, e_st3 = 1'b0;
  logic [15:0] m_sc1 = '0, m_sc3 = '0;

  always #5 clk = ~clk;

  store_fwd_hazard_unit #(.LOAD_USE_STALLS(1), .FWD_ALL(1'b0)) u1 (
    .clk(clk), .rst(rst), .memwb_md(memwb_md), .memwb_rw(memwb_rw), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .exmem_mw(exmem_mw), .exmem_rs2(exmem_rs2),
    .exmem_rs2_data(exmem_rs2_data), .idex_md(idex_md), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
    .ifid_use_rs2(ifid_use_rs2), .ifid_mw(ifid_mw), .flush(flush),
    .store_data(sd1), .lwsw_sel(sel1), .fwd_src(src1), .stall(st1), .stall_cycles(sc1)
  );

  store_fwd_hazard_unit #(.LOAD_USE_STALLS(3), .FWD_ALL(1'b1)) u3 (
    .clk(clk), .rst(rst), .memwb_md(memwb_md), .memwb_rw(memwb_rw), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .exmem_mw(exmem_mw), .exmem_rs2(exmem_rs2),
    .exmem_rs2_data(exmem_rs2_data), .idex_md(idex_md), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
    .ifid_use_rs2(ifid_use_rs2), .ifid_mw(ifid_mw), .flush(flush),
    .store_data(sd3), .lwsw_sel(sel3), .fwd_src(src3), .stall(st3), .stall_cycles(sc3)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got %h expected an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp_fwd(input logic s1, input logic [2:0] f1, input logic [31:0] d1,
                         input logic s3, input logic [2:0] f3, input logic [31:0] d3);
    push("u1_lwsw_sel", {31'd0, s1});
    push("u1_fwd_src", {29'd0, f1});
    push("u1_store_data", d1);
    push("u3_lwsw_sel", {31'd0, s3});
    push("u3_fwd_src", {29'd0, f3});
    push("u3_store_data", d3);
  endtask

  task automatic chk_fwd();
    #1;
    pop_chk({31'd0, sel1});
    pop_chk({29'd0, src1});
    pop_chk(sd1);
    pop_chk({31'd0, sel3});
    pop_chk({29'd0, src3});
    pop_chk(sd3);
  endtask

  task automatic exp_stall(input logic s1, input logic s3);
    e_st1 = s1;
    e_st3 = s3;
    push("u1_stall", {31'd0, s1});
    push("u3_stall", {31'd0, s3});
  endtask

  task automatic chk_stall();
    #1;
    pop_chk({31'd0, st1});
    pop_chk({31'd0, st3});
  endtask

  task automatic exp_sc();
    push("u1_stall_cycles", {16'd0, m_sc1});
    push("u3_stall_cycles", {16'd0, m_sc3});
  endtask

  task automatic chk_sc();
    pop_chk({16'd0, sc1});
    pop_chk({16'd0, sc3});
  endtask

  // Advance one clock, updating the reference counters with this cycle's stall.
  task automatic tick();
    @(posedge clk);
    if (e_st1 && m_sc1 != 16'hFFFF) m_sc1 = m_sc1 + 16'd1;
    if (e_st3 && m_sc3 != 16'hFFFF) m_sc3 = m_sc3 + 16'd1;
    #1;
  endtask

  // Quiet all inputs and let the history drain.
  task automatic idle();
    memwb_md = 2'b00; memwb_rw = 1'b0; memwb_rd = '0; memwb_data = '0;
    exmem_mw = 1'b0; exmem_rs2 = '0; exmem_rs2_data = '0;
    idex_md = 2'b00; idex_rd = '0;
    ifid_rs1 = '0; ifid_rs2 = '0; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0; ifid_mw = 1'b0;
    flush = 1'b0;
    e_st1 = 1'b0;
    e_st3 = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_load_use();
    idex_md = 2'b01; idex_rd = 5'd3;
    ifid_rs1 = 5'd3; ifid_use_rs1 = 1'b1; ifid_use_rs2 = 1'b0; ifid_mw = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    memwb_md = 2'b00; memwb_rw = 1'b0; memwb_rd = '0; memwb_data = '0;
    exmem_mw = 1'b1; exmem_rs2 = 5'd5; exmem_rs2_data = 32'hCAFE0000;
    idex_md = 2'b00; idex_rd = '0;
    ifid_rs1 = '0; ifid_rs2 = '0; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0; ifid_mw = 1'b0;
    flush = 1'b0;
    #2;
    // Reset state
    exp_stall(1'b0, 1'b0);
    chk_stall();
    exp_sc();
    chk_sc();
    exp_fwd(1'b0, 3'd0, 32'hCAFE0000, 1'b0, 3'd0, 32'hCAFE0000);
    chk_fwd();
    @(negedge clk);
    rst = 1'b0;
    idle();

    // 1: MEM/WB load forwards to the store
    memwb_md = 2'b01; memwb_rw = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hDEADBEEF;
    exmem_mw = 1'b1; exmem_rs2 = 5'd5; exmem_rs2_data = 32'h12345678;
    exp_fwd(1'b1, 3'd1, 32'hDEADBEEF, 1'b1, 3'd1, 32'hDEADBEEF);
    chk_fwd();
    exmem_mw = 1'b0;
    exp_fwd(1'b0, 3'd0, 32'h12345678, 1'b0, 3'd0, 32'h12345678);
    chk_fwd();
    exmem_mw = 1'b1; exmem_rs2 = 5'd0; memwb_rd = 5'd0;
    exp_fwd(1'b0, 3'd0, 32'h12345678, 1'b0, 3'd0, 32'h12345678);
    chk_fwd();
    idle();

    // 2: history priority and depth boundary
    memwb_md = 2'b01; memwb_rw = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h11;
    tick();
    memwb_data = 32'h22;
    exmem_mw = 1'b1; exmem_rs2 = 5'd7; exmem_rs2_data = 32'hAAAA;
    exp_fwd(1'b1, 3'd1, 32'h22, 1'b1, 3'd1, 32'h22);
    chk_fwd();
    memwb_rw = 1'b0;
    exp_fwd(1'b1, 3'd2, 32'h11, 1'b1, 3'd2, 32'h11);
    chk_fwd();
    tick();
    exp_fwd(1'b1, 3'd3, 32'h11, 1'b1, 3'd3, 32'h11);
    chk_fwd();
    tick();
    exp_fwd(1'b0, 3'd0, 32'hAAAA, 1'b0, 3'd0, 32'hAAAA);
    chk_fwd();
    idle();

    // 3: ALU writeback forwards only with FWD_ALL; rd/rs2 of zero never forwards
    memwb_md = 2'b00; memwb_rw = 1'b1; memwb_rd = 5'd5; memwb_data = 32'h55;
    exmem_mw = 1'b1; exmem_rs2 = 5'd5; exmem_rs2_data = 32'h99;
    exp_fwd(1'b0, 3'd0, 32'h99, 1'b1, 3'd1, 32'h55);
    chk_fwd();
    memwb_md = 2'b01; memwb_rd = 5'd0; memwb_data = 32'h77; exmem_rs2 = 5'd0;
    exp_fwd(1'b0, 3'd0, 32'h99, 1'b0, 3'd0, 32'h99);
    chk_fwd();
    idle();

    // 4: load-use stall length, then the store-rs2 and x0 exemptions
    set_load_use();
    exp_stall(1'b1, 1'b1);
    chk_stall();
    tick();
    idex_md = 2'b00;
    exp_stall(1'b0, 1'b1);
    chk_stall();
    tick();
    exp_stall(1'b0, 1'b1);
    chk_stall();
    tick();
    exp_stall(1'b0, 1'b0);
    chk_stall();
    exp_sc();
    chk_sc();
    idex_md = 2'b01; idex_rd = 5'd3;
    ifid_rs1 = 5'd3; ifid_use_rs1 = 1'b0; ifid_rs2 = 5'd3; ifid_use_rs2 = 1'b1; ifid_mw = 1'b1;
    exp_stall(1'b0, 1'b0);
    chk_stall();
    idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_use_rs1 = 1'b1; ifid_mw = 1'b0;
    exp_stall(1'b0, 1'b0);
    chk_stall();
    idle();

    // 5: flush priority in IDLE and mid-stall
    set_load_use();
    flush = 1'b1;
    exp_stall(1'b0, 1'b0);
    chk_stall();
    tick();
    flush = 1'b0;
    exp_stall(1'b1, 1'b1);
    chk_stall();
    tick();
    idex_md = 2'b00;
    flush = 1'b1;
    exp_stall(1'b0, 1'b0);
    chk_stall();
    tick();
    flush = 1'b0;
    exp_stall(1'b0, 1'b0);
    chk_stall();
    exp_sc();
    chk_sc();
    idle();

    // 6: saturation, then async reset mid-stall clears counter and history
    set_load_use();
    exp_stall(1'b1, 1'b1);
    chk_stall();
    repeat (70000) tick();
    exp_sc();
    chk_sc();
    memwb_md = 2'b01; memwb_rw = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h11;
    exmem_mw = 1'b1; exmem_rs2 = 5'd7; exmem_rs2_data = 32'hBB;
    tick();
    memwb_rw = 1'b0;
    exp_fwd(1'b1, 3'd2, 32'h11, 1'b1, 3'd2, 32'h11);
    chk_fwd();
    rst = 1'b1;
    m_sc1 = '0;
    m_sc3 = '0;
    exp_stall(1'b0, 1'b0);
    chk_stall();
    exp_sc();
    chk_sc();
    exp_fwd(1'b0, 3'd0, 32'hBB, 1'b0, 3'd0, 32'hBB);
    chk_fwd();
    tick();
    idex_md = 2'b00;
    #2;
    rst = 1'b0;
    exp_fwd(1'b0, 3'd0, 32'hBB, 1'b0, 3'd0, 32'hBB);
    chk_fwd();
    tick();
    exp_fwd(1'b0, 3'd0, 32'hBB, 1'b0, 3'd0, 32'hBB);
    chk_fwd();
    exp_sc();
    chk_sc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
